// File: rtl/sort4_arbiter.sv
// Two-requester round-robin front end for an external 4-input sort network.
// Accepted vectors are routed through the network and registered for one cycle.
module sort4_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req0_valid,
    output logic                      req0_ready,
    input  logic [4*DATA_WIDTH-1:0]   req0_data,
    input  logic                      req1_valid,
    output logic                      req1_ready,
    input  logic [4*DATA_WIDTH-1:0]   req1_data,
    output logic [DATA_WIDTH-1:0]     net_data_0,
    output logic [DATA_WIDTH-1:0]     net_data_1,
    output logic [DATA_WIDTH-1:0]     net_data_2,
    output logic [DATA_WIDTH-1:0]     net_data_3,
    input  logic [DATA_WIDTH-1:0]     net_sort_0,
    input  logic [DATA_WIDTH-1:0]     net_sort_1,
    input  logic [DATA_WIDTH-1:0]     net_sort_2,
    input  logic [DATA_WIDTH-1:0]     net_sort_3,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_id,
    output logic [4*DATA_WIDTH-1:0]   out_sort,
    output logic [CNT_WIDTH-1:0]      done_count
);

    logic                    last_grant;
    logic                    slot_free;
    logic                    gnt0_p0;
    logic                    gnt1_p0;
    logic [4*DATA_WIDTH-1:0] sel_data_p0;
    logic                    vld_p1;
    logic                    id_p1;
    logic [4*DATA_WIDTH-1:0] sort_p1;
    logic [CNT_WIDTH-1:0]    cnt_p1;

    // Stage p0: grant and operand routing into the external network
    always_comb begin
        slot_free   = !vld_p1 || out_ready;
        gnt0_p0     = !rst && slot_free && req0_valid && (!req1_valid || last_grant);
        gnt1_p0     = !rst && slot_free && req1_valid && (!req0_valid || !last_grant);
        sel_data_p0 = '0;
        if (gnt0_p0) begin
            sel_data_p0 = req0_data;
        end else if (gnt1_p0) begin
            sel_data_p0 = req1_data;
        end
    end

    assign req0_ready = gnt0_p0;
    assign req1_ready = gnt1_p0;
    assign net_data_0 = sel_data_p0[DATA_WIDTH*0 +: DATA_WIDTH];
    assign net_data_1 = sel_data_p0[DATA_WIDTH*1 +: DATA_WIDTH];
    assign net_data_2 = sel_data_p0[DATA_WIDTH*2 +: DATA_WIDTH];
    assign net_data_3 = sel_data_p0[DATA_WIDTH*3 +: DATA_WIDTH];

    // Stage p1: registered result slot and completion counter
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            id_p1      <= 1'b0;
            sort_p1    <= '0;
            cnt_p1     <= '0;
            last_grant <= 1'b1;
        end else begin
            if (gnt0_p0 || gnt1_p0) begin
                sort_p1    <= {net_sort_3, net_sort_2, net_sort_1, net_sort_0};
                id_p1      <= gnt1_p0;
                last_grant <= gnt1_p0;
                vld_p1     <= 1'b1;
            end else if (out_ready) begin
                vld_p1 <= 1'b0;
            end
            if (vld_p1 && out_ready) begin
                cnt_p1 <= cnt_p1 + CNT_WIDTH'(1);
            end
        end
    end

    assign out_valid  = vld_p1;
    assign out_id     = id_p1;
    assign out_sort   = sort_p1;
    assign done_count = cnt_p1;

endmodule
